// File: rtl/id_ex_latch.sv
// ID/EX pipeline register. It supports stall, flush (bubble insertion) and a debug step enable.
// It also keeps a saturating count of the bubble slots it has inserted or held.
module id_ex_latch #(
  parameter int N_BITS  = 32,
  parameter int N_REG   = 5,
  parameter int N_FIELD = 6,
  parameter int N_ALUOP = 2,
  parameter int N_CNT   = 16
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic [N_BITS-1:0]  i_pc4,
  input  logic [N_BITS-1:0]  i_dataA,
  input  logic [N_BITS-1:0]  i_dataB,
  input  logic [N_BITS-1:0]  i_imm,
  input  logic [N_REG-1:0]   i_rs,
  input  logic [N_REG-1:0]   i_rt,
  input  logic [N_REG-1:0]   i_rd,
  input  logic [N_REG-1:0]   i_shamt,
  input  logic [N_FIELD-1:0] i_funct,
  input  logic [N_FIELD-1:0] i_op,
  input  logic [N_ALUOP-1:0] i_aluOp,
  input  logic [6:0]         i_ctrl,
  output logic [N_BITS-1:0]  o_pc4,
  output logic [N_BITS-1:0]  o_dataA,
  output logic [N_BITS-1:0]  o_dataB,
  output logic [N_BITS-1:0]  o_imm,
  output logic [N_REG-1:0]   o_rs,
  output logic [N_REG-1:0]   o_rt,
  output logic [N_REG-1:0]   o_rd,
  output logic [N_REG-1:0]   o_shamt,
  output logic [N_FIELD-1:0] o_funct,
  output logic [N_FIELD-1:0] o_op,
  output logic [N_ALUOP-1:0] o_aluOp,
  output logic [6:0]         o_ctrl,
  output logic               o_valid,
  output logic [N_CNT-1:0]   o_bubbles
);

  // A bubble decodes as R-type funct 0 (SLL $0,$0,0) with every control bit cleared.
  localparam logic [N_ALUOP-1:0] ALUOP_BUBBLE = N_ALUOP'(2'b10);

  logic [N_BITS-1:0]  r_pc4, r_dataA, r_dataB, r_imm;
  logic [N_REG-1:0]   r_rs, r_rt, r_rd, r_shamt;
  logic [N_FIELD-1:0] r_funct, r_op;
  logic [N_ALUOP-1:0] r_aluOp;
  logic [6:0]         r_ctrl;
  logic               r_valid;
  logic [N_CNT-1:0]   r_bubbles;
  logic [N_CNT-1:0]   w_bubbles_inc;

  assign w_bubbles_inc = (r_bubbles == '1) ? r_bubbles : r_bubbles + N_CNT'(1);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_pc4     <= '0;
      r_dataA   <= '0;
      r_dataB   <= '0;
      r_imm     <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_shamt   <= '0;
      r_funct   <= '0;
      r_op      <= '0;
      r_aluOp   <= ALUOP_BUBBLE;
      r_ctrl    <= '0;
      r_valid   <= 1'b0;
      r_bubbles <= '0;
    end else if (i_enable) begin
      if (i_flush) begin
        r_pc4     <= '0;
        r_dataA   <= '0;
        r_dataB   <= '0;
        r_imm     <= '0;
        r_rs      <= '0;
        r_rt      <= '0;
        r_rd      <= '0;
        r_shamt   <= '0;
        r_funct   <= '0;
        r_op      <= '0;
        r_aluOp   <= ALUOP_BUBBLE;
        r_ctrl    <= '0;
        r_valid   <= 1'b0;
        r_bubbles <= w_bubbles_inc;
      end else if (i_stall) begin
        // The held slot is counted as a bubble, because the hazard unit neutralises it downstream.
        r_bubbles <= w_bubbles_inc;
      end else begin
        r_pc4     <= i_pc4;
        r_dataA   <= i_dataA;
        r_dataB   <= i_dataB;
        r_imm     <= i_imm;
        r_rs      <= i_rs;
        r_rt      <= i_rt;
        r_rd      <= i_rd;
        r_shamt   <= i_shamt;
        r_funct   <= i_funct;
        r_op      <= i_op;
        r_aluOp   <= i_aluOp;
        r_ctrl    <= i_ctrl;
        r_valid   <= 1'b1;
      end
    end
  end

  assign o_pc4     = r_pc4;
  assign o_dataA   = r_dataA;
  assign o_dataB   = r_dataB;
  assign o_imm     = r_imm;
  assign o_rs      = r_rs;
  assign o_rt      = r_rt;
  assign o_rd      = r_rd;
  assign o_shamt   = r_shamt;
  assign o_funct   = r_funct;
  assign o_op      = r_op;
  assign o_aluOp   = r_aluOp;
  assign o_ctrl    = r_ctrl;
  assign o_valid   = r_valid;
  assign o_bubbles = r_bubbles;

endmodule

// File: tb/tb_id_ex_latch.sv
// Bench for id_ex_latch. It applies directed and random steps and checks them against a slot-level reference model.
// A second instance with a 4-bit counter covers counter saturation.
module tb_id_ex_latch;

  typedef struct packed {
    logic [31:0] pc4, dataA, dataB, imm;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct, op;
    logic [1:0]  aluOp;
    logic [6:0]  ctrl;
    logic        valid;
  } slot_t;

  logic        clk = 1'b0;
  logic        i_reset, i_enable, i_stall, i_flush;
  logic [31:0] i_pc4, i_dataA, i_dataB, i_imm;
  logic [4:0]  i_rs, i_rt, i_rd, i_shamt;
  logic [5:0]  i_funct, i_op;
  logic [1:0]  i_aluOp;
  logic [6:0]  i_ctrl;

  logic [31:0] o_pc4, o_dataA, o_dataB, o_imm, s_pc4, s_dataA, s_dataB, s_imm;
  logic [4:0]  o_rs, o_rt, o_rd, o_shamt, s_rs, s_rt, s_rd, s_shamt;
  logic [5:0]  o_funct, o_op, s_funct, s_op;
  logic [1:0]  o_aluOp, s_aluOp;
  logic [6:0]  o_ctrl, s_ctrl;
  logic        o_valid, s_valid;
  logic [15:0] o_bubbles;
  logic [3:0]  s_bubbles;

  slot_t obs, s_obs, exp_slot;
  int    cnt, cnt4;
  int    checks = 0;
  int    failures = 0;

  localparam slot_t BUBBLE = '{aluOp: 2'b10, default: '0};

  always #5 clk = ~clk;

  id_ex_latch #(.N_CNT(16)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_enable(i_enable), .i_stall(i_stall), .i_flush(i_flush),
    .i_pc4(i_pc4), .i_dataA(i_dataA), .i_dataB(i_dataB), .i_imm(i_imm),
    .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_shamt(i_shamt),
    .i_funct(i_funct), .i_op(i_op), .i_aluOp(i_aluOp), .i_ctrl(i_ctrl),
    .o_pc4(o_pc4), .o_dataA(o_dataA), .o_dataB(o_dataB), .o_imm(o_imm),
    .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_shamt(o_shamt),
    .o_funct(o_funct), .o_op(o_op), .o_aluOp(o_aluOp), .o_ctrl(o_ctrl),
    .o_valid(o_valid), .o_bubbles(o_bubbles)
  );

  id_ex_latch #(.N_CNT(4)) u_sat (
    .i_clock(clk), .i_reset(i_reset), .i_enable(i_enable), .i_stall(i_stall), .i_flush(i_flush),
    .i_pc4(i_pc4), .i_dataA(i_dataA), .i_dataB(i_dataB), .i_imm(i_imm),
    .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_shamt(i_shamt),
    .i_funct(i_funct), .i_op(i_op), .i_aluOp(i_aluOp), .i_ctrl(i_ctrl),
    .o_pc4(s_pc4), .o_dataA(s_dataA), .o_dataB(s_dataB), .o_imm(s_imm),
    .o_rs(s_rs), .o_rt(s_rt), .o_rd(s_rd), .o_shamt(s_shamt),
    .o_funct(s_funct), .o_op(s_op), .o_aluOp(s_aluOp), .o_ctrl(s_ctrl),
    .o_valid(s_valid), .o_bubbles(s_bubbles)
  );

  assign obs   = {o_pc4, o_dataA, o_dataB, o_imm, o_rs, o_rt, o_rd, o_shamt,
                  o_funct, o_op, o_aluOp, o_ctrl, o_valid};
  assign s_obs = {s_pc4, s_dataA, s_dataB, s_imm, s_rs, s_rt, s_rd, s_shamt,
                  s_funct, s_op, s_aluOp, s_ctrl, s_valid};

  function automatic slot_t input_slot();
    return {i_pc4, i_dataA, i_dataB, i_imm, i_rs, i_rt, i_rd, i_shamt,
            i_funct, i_op, i_aluOp, i_ctrl, 1'b1};
  endfunction

  function automatic int sat_inc(input int v, input int max);
    return (v + 1 > max) ? max : v + 1;
  endfunction

  task automatic model_reset();
    exp_slot = BUBBLE;
    cnt = 0;
    cnt4 = 0;
  endtask

  // Applies one rising edge to the reference model.
  task automatic model_edge();
    if (!i_reset) model_reset();
    else if (!i_enable) ;
    else if (i_flush) begin
      exp_slot = BUBBLE;
      cnt  = sat_inc(cnt, 65535);
      cnt4 = sat_inc(cnt4, 15);
    end else if (i_stall) begin
      cnt  = sat_inc(cnt, 65535);
      cnt4 = sat_inc(cnt4, 15);
    end else exp_slot = input_slot();
  endtask

  task automatic check(input string tag);
    checks++;
    assert (obs === exp_slot) else begin
      failures++;
      $error("FAIL %s slot observed=%h expected=%h", tag, obs, exp_slot);
    end
    checks++;
    assert (o_bubbles === 16'(cnt)) else begin
      failures++;
      $error("FAIL %s bubbles observed=%0d expected=%0d", tag, o_bubbles, cnt);
    end
    checks++;
    assert (s_obs === exp_slot) else begin
      failures++;
      $error("FAIL %s sat_slot observed=%h expected=%h", tag, s_obs, exp_slot);
    end
    checks++;
    assert (s_bubbles === 4'(cnt4)) else begin
      failures++;
      $error("FAIL %s sat_bubbles observed=%0d expected=%0d", tag, s_bubbles, cnt4);
    end
    if (!o_valid) begin
      checks++;
      assert (o_ctrl[3] === 1'b0 && o_ctrl[1] === 1'b0) else begin
        failures++;
        $error("FAIL %s bubble_wr observed=%b expected=0x0x0x", tag, o_ctrl);
      end
    end
  endtask

  task automatic rand_inputs();
    i_pc4   = $urandom;
    i_dataA = $urandom;
    i_dataB = $urandom;
    i_imm   = $urandom;
    i_rs    = 5'($urandom);
    i_rt    = 5'($urandom);
    i_rd    = 5'($urandom);
    i_shamt = 5'($urandom);
    i_funct = 6'($urandom);
    i_op    = 6'($urandom);
    i_aluOp = 2'($urandom);
    i_ctrl  = 7'($urandom);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check(tag);
  endtask

  initial begin
    i_reset = 1'b1; i_enable = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
    rand_inputs();
    i_ctrl = 7'h7F;

    // Asynchronous reset, asserted before any clock edge.
    #3 i_reset = 1'b0;
    model_reset();
    #1 check("reset_async");
    i_enable = 1'b1;
    step("reset_held");
    #2 i_reset = 1'b1;

    // A normal load (LW-like).
    rand_inputs();
    i_op = 6'b100011; i_aluOp = 2'b00; i_dataA = 32'h10; i_imm = 32'h4; i_ctrl = 7'b0110110;
    step("normal_load");

    // Load an ADD, then hold it for 3 stalled edges while the inputs change.
    rand_inputs();
    i_op = 6'b000000; i_funct = 6'b100000; i_aluOp = 2'b10;
    step("load_add");
    i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rand_inputs();
      step("stall");
    end
    checks++;
    assert (o_funct === 6'b100000 && o_bubbles === 16'd3) else begin
      failures++;
      $error("FAIL stall_hold observed=%b/%0d expected=100000/3", o_funct, o_bubbles);
    end

    // Flush overrides stall.
    rand_inputs();
    i_ctrl = 7'h7F; i_flush = 1'b1;
    step("flush_over_stall");

    // Debug freeze: flush is ignored while the enable is low.
    i_enable = 1'b0; i_stall = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rand_inputs();
      step("freeze");
    end
    i_enable = 1'b1; i_flush = 1'b0;
    rand_inputs();
    step("unfreeze_load");

    // Random control mix.
    for (int k = 0; k < 300; k++) begin
      rand_inputs();
      i_enable = ($urandom_range(0, 9) != 0);
      i_flush  = ($urandom_range(0, 5) == 0);
      i_stall  = ($urandom_range(0, 4) == 0);
      step("random");
    end

    // Reset asserted mid-stall discards everything.
    i_enable = 1'b1; i_flush = 1'b0; i_stall = 1'b1;
    rand_inputs();
    step("pre_reset_stall");
    #2 i_reset = 1'b0;
    model_reset();
    #1 check("reset_mid_stall");
    #2 i_reset = 1'b1; i_stall = 1'b0;

    // Saturation of the 4-bit counter.
    i_flush = 1'b1;
    for (int k = 0; k < 20; k++) begin
      rand_inputs();
      step("saturate");
    end
    checks++;
    assert (s_bubbles === 4'd15 && o_bubbles === 16'd20) else begin
      failures++;
      $error("FAIL sat_final observed=%0d/%0d expected=15/20", s_bubbles, o_bubbles);
    end
    i_flush = 1'b0; i_stall = 1'b1;
    step("sat_hold");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_latch.md
Name: id_ex_latch

Overview:
- Pipeline register between instruction decode and execute.
- Captures decoded operands, register indices and control signals each cycle.
- Presents them to the execute stage, including the funct, op and aluOp fields consumed by the ALU control decoder.
- Supports hazard stall, branch/jump flush (bubble insertion), a debug-unit step enable, and a saturating bubble counter for debug readout.

Parameters:
N_BITS, 32, data/PC width
N_REG, 5, register index width
N_FIELD, 6, funct/op field width
N_ALUOP, 2, aluOp width
N_CNT, 16, bubble counter width

Ports:
i_clock  in  1  system clock, rising edge
i_reset  in  1  asynchronous reset, active-low
i_enable  in  1  debug-unit step enable; 0 freezes the whole latch
i_stall  in  1  hazard unit: hold current contents
i_flush  in  1  branch/jump taken: insert bubble
i_pc4  in  N_BITS  PC+4 from decode
i_dataA  in  N_BITS  register file read A
i_dataB  in  N_BITS  register file read B
i_imm  in  N_BITS  sign-extended immediate
i_rs / i_rt / i_rd  in  N_REG each  register indices
i_shamt  in  N_REG  shift amount
i_funct  in  N_FIELD  instr[5:0]
i_op  in  N_FIELD  instr[31:26]
i_aluOp  in  N_ALUOP  ALU control class
i_ctrl  in  7  {regDst, aluSrc, memRead, memWrite, memToReg, regWrite, branch}
o_pc4, o_dataA, o_dataB, o_imm  out  N_BITS  registered copies
o_rs, o_rt, o_rd, o_shamt  out  N_REG  registered copies
o_funct, o_op  out  N_FIELD  registered, to ALU control
o_aluOp  out  N_ALUOP  registered, to ALU control
o_ctrl  out  7  registered control
o_valid  out  1  1 = real instruction, 0 = bubble
o_bubbles  out  N_CNT  count of bubbles inserted since reset

Behaviour:
- All outputs are registers; latency is one i_clock edge from inputs to outputs. There is no combinational input-to-output path.
- Reset (i_reset=0, asynchronous, no clock needed) forces the bubble state:
  - all data, index and field outputs = 0;
  - o_aluOp = 2'b10, o_funct = 6'b000000 (decodes as SLL $0,$0,0, a harmless NOP);
  - o_ctrl = 0, o_valid = 0, o_bubbles = 0.
- Reset release takes effect on the next rising edge. Reset mid-stall or mid-flush discards everything; no state survives.
- Per rising edge, priority is highest first:
  - i_enable=0: hold all registers; i_flush and i_stall are ignored; the counter holds.
  - i_flush=1: load the bubble state (same values as reset) and set o_valid=0. o_bubbles increments. Flush overrides stall.
  - i_stall=1: hold all registers, o_valid unchanged. o_bubbles increments, because downstream sees a duplicated/held slot that the hazard unit neutralises elsewhere.
  - Otherwise: load all inputs and set o_valid=1.
- o_bubbles saturates at 2^N_CNT-1 and never wraps.
- The bubble must never assert memWrite or regWrite, whatever the inputs are.
- No field is modified or re-encoded. o_funct, o_op and o_aluOp are bit-exact copies of the captured inputs.

Test Plan:
- Reset then idle: drive i_reset=0 asynchronously mid-cycle -> outputs go to the bubble state immediately (o_aluOp=2'b10, o_funct=0, o_ctrl=0, o_valid=0, o_bubbles=0) without waiting for a clock edge.
- Normal load: i_enable=1, i_op=6'b100011, i_aluOp=2'b00, i_dataA=32'h10, i_imm=32'h4, i_ctrl=7'b0110110 -> all outputs match one edge later; o_valid=1.
- Stall: load ADD (i_funct=6'b100000, i_aluOp=2'b10), then i_stall=1 for 3 cycles with changing inputs -> outputs stay at ADD; o_bubbles=3.
- Flush over stall: i_stall=1 and i_flush=1 on the same edge with i_ctrl=7'h7F -> bubble loaded, o_ctrl=0, o_valid=0, o_bubbles increments by 1.
- Debug freeze: i_enable=0 with i_flush=1 for 5 cycles -> outputs and o_bubbles unchanged. Raising i_enable for one edge captures current inputs.
- Counter saturation: with N_CNT=4, apply 20 flushes -> o_bubbles=15 and holds at 15.
